// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480 raster constants and shared timing types
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF      = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF      = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  typedef logic [9:0] coord_t;

  // Bit order {hs, vs, blank} is what the delay line carries.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_terms_t;

  // Idle raster state: both syncs inactive (high), output blanked.
  localparam sync_terms_t SYNC_TERMS_RST = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  // Half-open interval test [lo, hi).
  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - enable-gated shift register that realigns sync/blank with downstream RGB
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst ^ en;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per pixel; reset clears every stage at once.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel strobe, pixel clock, scan counters, sync/blank
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int CLK_DIV   = 2,
  parameter int PIPE_DLY  = 1
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   pixel_ce,
  output logic   VGA_Clk,
  output logic   hs,
  output logic   vs,
  output logic   blank,
  output logic   sync,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   frame_end
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  localparam int               DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_pipe_dly
    $error("vga_timing_gen: PIPE_DLY must be in 0..4");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
    $error("vga_timing_gen: raster totals must fit 10-bit counters");
  end

  logic [DIV_W-1:0] div_cnt;
  coord_t           x_next;
  coord_t           y_next;
  sync_terms_t      terms_next;
  sync_terms_t      terms_q;
  sync_terms_t      terms_dly;

  // Clock divider: free-running 0..CLK_DIV-1 count, both pixel strobe and pixel clock decode from it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign pixel_ce = (div_cnt == DIV_LAST);
  assign VGA_Clk  = (div_cnt >= DIV_HALF);

  // Next scan position: column wraps at end of line and carries into the line count.
  always_comb begin
    x_next = DrawX + 10'd1;
    y_next = DrawY;
    if (DrawX == H_LAST) begin
      x_next = '0;
      y_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
    end
  end

  // Terms are decoded from the next position so that, once registered, they line up with DrawX/DrawY.
  always_comb begin
    terms_next       = SYNC_TERMS_RST;
    terms_next.hs    = !in_span(x_next, HS_START, HS_END);
    terms_next.vs    = !in_span(y_next, VS_START, VS_END);
    terms_next.blank = (x_next < H_VIS) && (y_next < V_VIS);
  end

  // Scan counters and their aligned sync/blank terms advance once per pixel.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DrawX   <= '0;
      DrawY   <= '0;
      terms_q <= SYNC_TERMS_RST;
    end else if (pixel_ce) begin
      DrawX   <= x_next;
      DrawY   <= y_next;
      terms_q <= terms_next;
    end
  end

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_TERMS_RST)
  ) u_sync_delay_line (
    .clk (Clk),
    .rst (Reset),
    .en  (pixel_ce),
    .d   (terms_q),
    .q   (terms_dly)
  );

  assign hs        = terms_dly.hs;
  assign vs        = terms_dly.vs;
  assign blank     = terms_dly.blank;
  assign sync      = 1'b0;
  assign frame_end = pixel_ce && (DrawX == H_LAST) && (DrawY == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed-vector bench for vga_timing_gen across four builds
module tb_vga_timing_gen;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  always #10 Clk = ~Clk;

  // d_: defaults; p_: PIPE_DLY=0; q_: CLK_DIV=4; s_: 16x9 raster.
  logic       d_ce, d_vclk, d_hs, d_vs, d_blank, d_sync, d_fe;
  logic [9:0] d_x, d_y;
  logic       p_ce, p_vclk, p_hs, p_vs, p_blank, p_sync, p_fe;
  logic [9:0] p_x, p_y;
  logic       q_ce, q_vclk, q_hs, q_vs, q_blank, q_sync, q_fe;
  logic [9:0] q_x, q_y;
  logic       s_ce, s_vclk, s_hs, s_vs, s_blank, s_sync, s_fe;
  logic [9:0] s_x, s_y;

  vga_timing_gen u_def (
    .Clk(Clk), .Reset(Reset), .pixel_ce(d_ce), .VGA_Clk(d_vclk), .hs(d_hs), .vs(d_vs),
    .blank(d_blank), .sync(d_sync), .DrawX(d_x), .DrawY(d_y), .frame_end(d_fe)
  );

  vga_timing_gen #(.PIPE_DLY(0)) u_p0 (
    .Clk(Clk), .Reset(Reset), .pixel_ce(p_ce), .VGA_Clk(p_vclk), .hs(p_hs), .vs(p_vs),
    .blank(p_blank), .sync(p_sync), .DrawX(p_x), .DrawY(p_y), .frame_end(p_fe)
  );

  vga_timing_gen #(.CLK_DIV(4)) u_d4 (
    .Clk(Clk), .Reset(Reset), .pixel_ce(q_ce), .VGA_Clk(q_vclk), .hs(q_hs), .vs(q_vs),
    .blank(q_blank), .sync(q_sync), .DrawX(q_x), .DrawY(q_y), .frame_end(q_fe)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_sm (
    .Clk(Clk), .Reset(Reset), .pixel_ce(s_ce), .VGA_Clk(s_vclk), .hs(s_hs), .vs(s_vs),
    .blank(s_blank), .sync(s_sync), .DrawX(s_x), .DrawY(s_y), .frame_end(s_fe)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int p0_bad = 0;
  int d4_bad = 0;
  int sync_bad = 0;
  int def_hs_low = 0;
  int def_fe = 0;
  int sm_fe = 0;
  int sm_vs_low = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ce"},    d_ce,    0);
    chk({tag, "_vclk"},  d_vclk,  0);
    chk({tag, "_hs"},    d_hs,    1);
    chk({tag, "_vs"},    d_vs,    1);
    chk({tag, "_blank"}, d_blank, 0);
    chk({tag, "_sync"},  d_sync,  0);
    chk({tag, "_x"},     d_x,     0);
    chk({tag, "_y"},     d_y,     0);
    chk({tag, "_fe"},    d_fe,    0);
    chk({tag, "_p0_blank"}, p_blank, 0);
    chk({tag, "_d4_ce"},    q_ce,    0);
    chk({tag, "_sm_x"},     s_x,     0);
  endtask

  // k = Clk rising edges since reset release; sampled on the falling edge.
  task automatic step_checks(input int k);
    int p;
    int x;
    int y;
    if (k >= 2) begin
      p = k / 2;
      x = p % 800;
      y = p / 800;
      if (p_hs !== !(x >= 656 && x < 752)) p0_bad++;
      if (p_blank !== (x < 640 && y < 480)) p0_bad++;
      if (p_x !== 10'(x) || p_y !== 10'(y)) p0_bad++;
    end
    if (q_ce !== (k % 4 == 3)) d4_bad++;
    if (q_vclk !== (k % 4 >= 2)) d4_bad++;
    if (q_x !== 10'((k / 4) % 800)) d4_bad++;
    if (d_sync !== 1'b0 || p_sync !== 1'b0 || q_sync !== 1'b0 || s_sync !== 1'b0) sync_bad++;
    if (k <= 1600 && d_hs === 1'b0) def_hs_low++;
    if (d_fe === 1'b1) def_fe++;
    if (s_fe === 1'b1) sm_fe++;
    if (k <= 288 && s_vs === 1'b0) sm_vs_low++;

    case (k)
      1: begin
        chk("rel_ce_k1", d_ce, 1); chk("rel_vclk_k1", d_vclk, 1); chk("rel_x_k1", d_x, 0);
      end
      2: begin
        chk("rel_ce_k2", d_ce, 0); chk("rel_vclk_k2", d_vclk, 0); chk("rel_x_k2", d_x, 1);
      end
      3: chk("rel_ce_k3", d_ce, 1);
      4: chk("def_blank_vis", d_blank, 1);
      161: chk("sm_vs_before", s_vs, 1);
      162: chk("sm_vs_fall", s_vs, 0);
      225: chk("sm_vs_last_low", s_vs, 0);
      226: chk("sm_vs_rise", s_vs, 1);
      286: chk("sm_fe_early", s_fe, 0);
      287: begin
        chk("sm_fe_pulse", s_fe, 1); chk("sm_x_last", s_x, 15); chk("sm_y_last", s_y, 8);
      end
      288: begin
        chk("sm_fe_after", s_fe, 0); chk("sm_x_wrap", s_x, 0); chk("sm_y_wrap", s_y, 0);
        chk("sm_vs_low_clk", sm_vs_low, 64);
      end
      1279: chk("p0_blank_639", p_blank, 1);
      1280: chk("p0_blank_640", p_blank, 0);
      1281: chk("def_blank_640", d_blank, 1);
      1282: chk("def_blank_641", d_blank, 0);
      1311: chk("p0_hs_655", p_hs, 1);
      1312: chk("p0_hs_656", p_hs, 0);
      1313: chk("def_hs_656", d_hs, 1);
      1314: chk("def_hs_657", d_hs, 0);
      1503: chk("p0_hs_751", p_hs, 0);
      1504: chk("p0_hs_752", p_hs, 1);
      1505: chk("def_hs_752", d_hs, 0);
      1506: chk("def_hs_753", d_hs, 1);
      1599: begin chk("def_x_799", d_x, 799); chk("def_y_line0", d_y, 0); end
      1600: begin
        chk("def_x_wrap", d_x, 0); chk("def_y_line1", d_y, 1);
        chk("def_hs_low_clk", def_hs_low, 192);
      end
      3001: begin
        chk("def_x_700", d_x, 700); chk("def_y_700", d_y, 1);
        chk("def_hs_700", d_hs, 0); chk("def_ce_3001", d_ce, 1);
      end
      3199: begin chk("d4_x_799", q_x, 799); chk("d4_y_line0", q_y, 0); end
      3200: begin chk("d4_x_wrap", q_x, 0); chk("d4_y_line1", q_y, 1); end
      3401: begin
        chk("def_x_100", d_x, 100); chk("def_y_2", d_y, 2);
        chk("def_blank_mid", d_blank, 1); chk("def_ce_mid", d_ce, 1);
      end
      default: ;
    endcase
  endtask

  initial begin
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk_reset("init");
    Reset = 1'b0;

    for (int k = 1; k <= 3401; k++) begin
      @(negedge Clk);
      step_checks(k);
    end

    chk("p0_sweep_bad", p0_bad, 0);
    chk("d4_sweep_bad", d4_bad, 0);
    chk("sync_held_low", sync_bad, 0);
    chk("def_fe_count", def_fe, 0);
    chk("sm_fe_count", sm_fe, 11);

    // Mid-line asynchronous reset, applied halfway between rising edges.
    Reset = 1'b1;
    #1;
    chk_reset("async");
    repeat (2) @(negedge Clk);
    chk_reset("held");
    Reset = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      case (k)
        1: begin
          chk("rst2_ce_k1", d_ce, 1); chk("rst2_hs_k1", d_hs, 1);
          chk("rst2_blank_k1", d_blank, 0); chk("rst2_x_k1", d_x, 0);
        end
        2: begin
          chk("rst2_x_k2", d_x, 1); chk("rst2_y_k2", d_y, 0); chk("rst2_hs_k2", d_hs, 1);
        end
        4: begin
          chk("rst2_x_k4", d_x, 2); chk("rst2_blank_k4", d_blank, 1);
        end
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
